// File: rtl/srcctl_seq.sv
// ----------------------------------------------------------------------------
// srcctl_seq
// Multi-channel, multi-stage sequencer for the sample rate converter datapath.
// One accepted input sample walks every entry of a programmable stage table.
// For each stage the sample is written into the channel's ring buffer, the MAC
// tap sequence is issued newest-to-oldest, and the result is stored in the
// register file. A completion handshake closes the frame.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   prog_we/prog_addr/prog_word  stage-table write {base, len, coef_base, rd}
//   in_valid/in_ch/in_ready    sample handshake (in_ready = idle)
//   out_valid/out_ch/out_ready frame-complete handshake
//   data_we/data_re/coef_re    RAM strobes
//   data_addr/coef_addr        RAM addresses (hold when unused)
//   mac_init/accum             MAC controls (first tap / later taps)
//   new_in                     datapath drives the input sample onto RAM write
//   regf_wr/ard                register-file write and destination
//   stage                      current stage index
// All outputs are registered: each is loaded with the value that belongs to
// the state the FSM enters on the same edge.
// ----------------------------------------------------------------------------
module srcctl_seq #(
    parameter  int CHANNELS = 2,
    parameter  int STAGES   = 4,
    parameter  int ADDR_W   = 6,
    parameter  int LEN_W    = 4,
    parameter  int RF_AW    = 3,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ST_W     = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int PW       = 2*ADDR_W + LEN_W + RF_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ST_W-1:0]   prog_addr,
    input  logic [PW-1:0]     prog_word,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    input  logic              out_ready,
    output logic              data_we,
    output logic              data_re,
    output logic              coef_re,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_init,
    output logic              accum,
    output logic              new_in,
    output logic              regf_wr,
    output logic [RF_AW-1:0]  ard,
    output logic [ST_W-1:0]   stage
);

    localparam int CH_D     = 2**CH_W;
    localparam int TBL_D    = 2**ST_W;
    localparam int RW       = ADDR_W + CH_W + LEN_W + 1;
    localparam int RD_LSB   = 0;
    localparam int CB_LSB   = RF_AW;
    localparam int LEN_LSB  = RF_AW + ADDR_W;
    localparam int BASE_LSB = RF_AW + ADDR_W + LEN_W;
    localparam logic [ST_W-1:0] LAST_ST = ST_W'(STAGES - 1);

    // One bit per encodable channel number: set when that channel exists.
    function automatic logic [CH_D-1:0] ch_mask_f();
        logic [CH_D-1:0] m;
        m = {CH_D{1'b0}};
        for (int i = 0; i < CH_D; i++) begin
            if (i < CHANNELS) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    localparam logic [CH_D-1:0] CH_OK = ch_mask_f();

    // ring(i) = base + ch*2^LEN_W + i, wrapped to the RAM address width.
    function automatic logic [ADDR_W-1:0] ring_addr(
        input logic [CH_W-1:0]   ch,
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  idx
    );
        logic [RW-1:0] sum;
        sum = RW'(base) + (RW'(ch) << LEN_W) + RW'(idx);
        return sum[ADDR_W-1:0];
    endfunction

    // (head + k) mod L; also folds a stale head that exceeds a shorter len.
    function automatic logic [LEN_W-1:0] ring_idx(
        input logic [LEN_W-1:0] head,
        input logic [LEN_W-1:0] k,
        input logic [LEN_W-1:0] len
    );
        logic [LEN_W:0] sum;
        logic [LEN_W:0] span;
        sum  = {1'b0, head} + {1'b0, k};
        span = {1'b0, len} + (LEN_W+1)'(1);
        return LEN_W'(sum % span);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_MAC   = 3'd3,
        ST_STORE = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [CH_W-1:0]   ch_r, ch_s;
    logic [ST_W-1:0]   s_r, s_s;
    logic [LEN_W-1:0]  k_r, k_s;
    logic [PW-1:0]     work_r;
    logic [PW-1:0]     table_r [TBL_D];
    logic [LEN_W-1:0]  head_r  [CH_D][TBL_D];

    logic [PW-1:0]     entry_s;
    logic [ADDR_W-1:0] base_s, cbase_s;
    logic [LEN_W-1:0]  len_s, work_len_s, head_cur_s, cur_head_s;
    logic [RF_AW-1:0]  rd_s;

    logic              in_ready_s, out_valid_s, data_we_s, data_re_s, coef_re_s;
    logic              mac_init_s, accum_s, new_in_s, regf_wr_s;
    logic [CH_W-1:0]   out_ch_s;
    logic [ADDR_W-1:0] data_addr_s, coef_addr_s;
    logic [RF_AW-1:0]  ard_s;

    logic              in_ready_r, out_valid_r, data_we_r, data_re_r, coef_re_r;
    logic              mac_init_r, accum_r, new_in_r, regf_wr_r;
    logic [CH_W-1:0]   out_ch_r;
    logic [ADDR_W-1:0] data_addr_r, coef_addr_r;
    logic [RF_AW-1:0]  ard_r;
    logic [ST_W-1:0]   stage_r;

    // Stage entry seen by the next state: the table while fetching, else the
    // working copy (so a WRITE entered from FETCH already sees the new entry).
    always_comb begin
        entry_s = work_r;
        if (state_r == ST_FETCH) begin
            entry_s = table_r[s_r];
        end else begin
            entry_s = work_r;
        end
        base_s     = entry_s[BASE_LSB +: ADDR_W];
        len_s      = entry_s[LEN_LSB  +: LEN_W];
        cbase_s    = entry_s[CB_LSB   +: ADDR_W];
        rd_s       = entry_s[RD_LSB   +: RF_AW];
        work_len_s = work_r[LEN_LSB   +: LEN_W];
        cur_head_s = head_r[ch_r][s_r];
    end

    // Next-state logic for the frame walk.
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        s_s     = s_r;
        k_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                // Out-of-range channels are accepted (in_ready is high) and dropped.
                if (in_valid && CH_OK[in_ch]) begin
                    ch_s    = in_ch;
                    s_s     = {ST_W{1'b0}};
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: state_s = ST_WRITE;
            ST_WRITE: begin
                k_s     = {LEN_W{1'b0}};
                state_s = ST_MAC;
            end
            ST_MAC: begin
                if (k_r == work_len_s) begin
                    state_s = ST_STORE;
                end else begin
                    k_s = k_r + LEN_W'(1);
                end
            end
            ST_STORE: begin
                if (s_r == LAST_ST) begin
                    state_s = ST_OUT;
                end else begin
                    s_s     = s_r + ST_W'(1);
                    state_s = ST_FETCH;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; addresses hold when unused.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        data_we_s   = 1'b0;
        data_re_s   = 1'b0;
        coef_re_s   = 1'b0;
        mac_init_s  = 1'b0;
        accum_s     = 1'b0;
        new_in_s    = 1'b0;
        regf_wr_s   = 1'b0;
        out_ch_s    = out_ch_r;
        data_addr_s = data_addr_r;
        coef_addr_s = coef_addr_r;
        ard_s       = ard_r;
        head_cur_s  = head_r[ch_s][s_s];
        case (state_s)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_FETCH: in_ready_s = 1'b0;
            ST_WRITE: begin
                data_we_s   = 1'b1;
                new_in_s    = 1'b1;
                data_addr_s = ring_addr(ch_s, base_s, head_cur_s);
            end
            ST_MAC: begin
                data_re_s   = 1'b1;
                coef_re_s   = 1'b1;
                data_addr_s = ring_addr(ch_s, base_s, ring_idx(head_cur_s, k_s, len_s));
                coef_addr_s = cbase_s + ADDR_W'(k_s);
                mac_init_s  = (k_s == {LEN_W{1'b0}});
                accum_s     = (k_s != {LEN_W{1'b0}});
            end
            ST_STORE: begin
                regf_wr_s = 1'b1;
                ard_s     = rd_s;
            end
            ST_OUT: begin
                out_valid_s = 1'b1;
                out_ch_s    = ch_s;
            end
            default: in_ready_s = 1'b0;
        endcase
    end

    // FSM, frame context and working entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ch_r    <= {CH_W{1'b0}};
            s_r     <= {ST_W{1'b0}};
            k_r     <= {LEN_W{1'b0}};
            work_r  <= {PW{1'b0}};
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            s_r     <= s_s;
            k_r     <= k_s;
            if (state_r == ST_FETCH) begin
                work_r <= table_r[s_r];
            end
        end
    end

    // Stage table: host writes land only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TBL_D; t++) begin
                table_r[t] <= {PW{1'b0}};
            end
        end else if (state_r == ST_IDLE && prog_we) begin
            table_r[prog_addr] <= prog_word;
        end
    end

    // Ring head per channel/stage, decremented with wrap to len at each STORE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_D; c++) begin
                for (int t = 0; t < TBL_D; t++) begin
                    head_r[c][t] <= {LEN_W{1'b0}};
                end
            end
        end else if (state_r == ST_STORE) begin
            if (cur_head_s == {LEN_W{1'b0}}) begin
                head_r[ch_r][s_r] <= work_len_s;
            end else begin
                head_r[ch_r][s_r] <= cur_head_s - LEN_W'(1);
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_ch_r    <= {CH_W{1'b0}};
            data_we_r   <= 1'b0;
            data_re_r   <= 1'b0;
            coef_re_r   <= 1'b0;
            data_addr_r <= {ADDR_W{1'b0}};
            coef_addr_r <= {ADDR_W{1'b0}};
            mac_init_r  <= 1'b0;
            accum_r     <= 1'b0;
            new_in_r    <= 1'b0;
            regf_wr_r   <= 1'b0;
            ard_r       <= {RF_AW{1'b0}};
            stage_r     <= {ST_W{1'b0}};
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_ch_r    <= out_ch_s;
            data_we_r   <= data_we_s;
            data_re_r   <= data_re_s;
            coef_re_r   <= coef_re_s;
            data_addr_r <= data_addr_s;
            coef_addr_r <= coef_addr_s;
            mac_init_r  <= mac_init_s;
            accum_r     <= accum_s;
            new_in_r    <= new_in_s;
            regf_wr_r   <= regf_wr_s;
            ard_r       <= ard_s;
            stage_r     <= s_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign data_we   = data_we_r;
    assign data_re   = data_re_r;
    assign coef_re   = coef_re_r;
    assign data_addr = data_addr_r;
    assign coef_addr = coef_addr_r;
    assign mac_init  = mac_init_r;
    assign accum     = accum_r;
    assign new_in    = new_in_r;
    assign regf_wr   = regf_wr_r;
    assign ard       = ard_r;
    assign stage     = stage_r;

endmodule

// File: tb/tb_srcctl_seq.sv
// Self-checking bench for srcctl_seq. Three channels are instantiated so that
// channel number 3 is encodable and exercises the drop of out-of-range samples.
// The reference model keeps the stage table and ring heads as plain integers
// and derives every expected cycle of a frame from the sequencing rules.
module tb_srcctl_seq;

    localparam int CHANNELS = 3;
    localparam int STAGES   = 4;
    localparam int ADDR_W   = 6;
    localparam int LEN_W    = 4;
    localparam int RF_AW    = 3;
    localparam int CH_W     = 2;
    localparam int ST_W     = 2;
    localparam int PW       = 2*ADDR_W + LEN_W + RF_AW;

    localparam logic [8:0] E_NONE  = 9'b0_0000_0000;
    localparam logic [8:0] E_IDLE  = 9'b1_0000_0000;
    localparam logic [8:0] E_OUT   = 9'b0_1000_0000;
    localparam logic [8:0] E_WRITE = 9'b0_0100_1000;
    localparam logic [8:0] E_MAC0  = 9'b0_0011_0100;
    localparam logic [8:0] E_MACN  = 9'b0_0011_0010;
    localparam logic [8:0] E_STORE = 9'b0_0000_0001;

    logic              clk, rst_n;
    logic              prog_we;
    logic [ST_W-1:0]   prog_addr;
    logic [PW-1:0]     prog_word;
    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic              in_ready, out_valid, out_ready;
    logic [CH_W-1:0]   out_ch;
    logic              data_we, data_re, coef_re, mac_init, accum, new_in, regf_wr;
    logic [ADDR_W-1:0] data_addr, coef_addr;
    logic [RF_AW-1:0]  ard;
    logic [ST_W-1:0]   stage;
    logic [8:0]        strb;

    srcctl_seq #(
        .CHANNELS(CHANNELS), .STAGES(STAGES), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .RF_AW(RF_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_word(prog_word),
        .in_valid(in_valid), .in_ch(in_ch), .in_ready(in_ready),
        .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready),
        .data_we(data_we), .data_re(data_re), .coef_re(coef_re),
        .data_addr(data_addr), .coef_addr(coef_addr),
        .mac_init(mac_init), .accum(accum), .new_in(new_in),
        .regf_wr(regf_wr), .ard(ard), .stage(stage)
    );

    assign strb = {in_ready, out_valid, data_we, data_re, coef_re,
                   new_in, mac_init, accum, regf_wr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    int m_base [STAGES];
    int m_len  [STAGES];
    int m_cb   [STAGES];
    int m_rd   [STAGES];
    int m_head [CHANNELS][STAGES];

    function automatic int ring(input int ch, input int base, input int i);
        return (base + ch * (1 << LEN_W) + i) % (1 << ADDR_W);
    endfunction

    function automatic logic [PW-1:0] pack(input int b, input int l, input int c, input int r);
        return {ADDR_W'(b), LEN_W'(l), ADDR_W'(c), RF_AW'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Negative expectation arguments mean "not checked in this cycle".
    task automatic expect_cyc(input string tag, input logic [8:0] es, input int s,
                              input int da, input int ca, input int ar, input int oc);
        chk({tag, "/strobes"}, 32'(strb), 32'(es));
        if (s >= 0)  chk({tag, "/stage"},     32'(stage),     s);
        if (da >= 0) chk({tag, "/data_addr"}, 32'(data_addr), da);
        if (ca >= 0) chk({tag, "/coef_addr"}, 32'(coef_addr), ca);
        if (ar >= 0) chk({tag, "/ard"},       32'(ard),       ar);
        if (oc >= 0) chk({tag, "/out_ch"},    32'(out_ch),    oc);
    endtask

    task automatic prog(input int a, input int b, input int l, input int c, input int r);
        prog_we   = 1'b1;
        prog_addr = ST_W'(a);
        prog_word = pack(b, l, c, r);
        step();
        prog_we   = 1'b0;
        m_base[a] = b;
        m_len[a]  = l;
        m_cb[a]   = c;
        m_rd[a]   = r;
    endtask

    task automatic model_reset();
        for (int s = 0; s < STAGES; s++) begin
            m_base[s] = 0; m_len[s] = 0; m_cb[s] = 0; m_rd[s] = 0;
            for (int c = 0; c < CHANNELS; c++) m_head[c][s] = 0;
        end
    endtask

    // One complete frame. hold = cycles of out_ready low in OUT; busy_prog
    // drives table writes during the frame (must be ignored); same_prog writes
    // entry 0 with len=pl on the accept edge (must be used by this frame).
    task automatic run_frame(input int ch, input int hold, input bit busy_prog,
                             input bit same_prog, input int pl);
        chk("accept/in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        if (same_prog) begin
            prog_we   = 1'b1;
            prog_addr = ST_W'(0);
            prog_word = pack(m_base[0], pl, m_cb[0], m_rd[0]);
            m_len[0]  = pl;
        end
        step();
        in_valid = 1'b0;
        prog_we  = 1'b0;
        if (busy_prog) begin
            prog_we   = 1'b1;
            prog_addr = ST_W'($urandom_range(0, STAGES - 1));
            prog_word = PW'($urandom);
        end
        for (int s = 0; s < STAGES; s++) begin
            int h;
            int L;
            h = m_head[ch][s];
            L = m_len[s] + 1;
            expect_cyc("fetch", E_NONE, s, -1, -1, -1, -1);
            step();
            expect_cyc("write", E_WRITE, s, ring(ch, m_base[s], h), -1, -1, -1);
            step();
            for (int k = 0; k < L; k++) begin
                expect_cyc((k == 0) ? "mac_first" : "mac_tap", (k == 0) ? E_MAC0 : E_MACN, s,
                           ring(ch, m_base[s], (h + k) % L),
                           (m_cb[s] + k) % (1 << ADDR_W), -1, -1);
                step();
            end
            expect_cyc("store", E_STORE, s, -1, -1, m_rd[s], -1);
            step();
            m_head[ch][s] = (h == 0) ? (L - 1) : (h - 1);
        end
        prog_we = 1'b0;
        for (int j = 0; j < hold; j++) begin
            expect_cyc("out_hold", E_OUT, STAGES - 1, -1, -1, -1, ch);
            in_valid = 1'($urandom);
            in_ch    = CH_W'($urandom_range(0, CHANNELS - 1));
            step();
        end
        in_valid = 1'b0;
        expect_cyc("out", E_OUT, STAGES - 1, -1, -1, -1, ch);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        expect_cyc("release", E_IDLE, -1, -1, -1, -1, -1);
    endtask

    task automatic drop_frame();
        chk("drop/in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_ch    = CH_W'(3);
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            expect_cyc("drop", E_IDLE, -1, -1, -1, -1, -1);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_word = '0;
        in_valid = 1'b0; in_ch = '0; out_ready = 1'b0;
        model_reset();
        step();
        step();
        expect_cyc("reset", E_IDLE, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();

        // Single frame: len=3, base=0, coef_base=16, rd=s.
        for (int s = 0; s < STAGES; s++) prog(s, 0, 3, 16, s);
        run_frame(0, 0, 1'b0, 1'b0, 0);

        // Ring wrap on channel 1, base 8: writes at 24,27,26,25,24.
        for (int s = 0; s < STAGES; s++) prog(s, 8, 3, 16, s);
        for (int f = 0; f < 5; f++) run_frame(1, 0, 1'b0, 1'b0, 0);

        // Channel isolation.
        for (int f = 0; f < 4; f++) run_frame(f % 2, $urandom_range(0, 2), 1'b0, 1'b0, 0);
        drop_frame();

        // Backpressure for 10 cycles.
        run_frame(0, 10, 1'b0, 1'b0, 0);

        // Writes while busy are ignored; write with accept is used at once.
        run_frame(1, 0, 1'b1, 1'b0, 0);
        run_frame(1, 0, 1'b0, 1'b0, 0);
        run_frame(0, 0, 1'b0, 1'b1, 0);
        run_frame(2, 1, 1'b0, 1'b0, 0);

        // Randomised tables and frames.
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < STAGES; s++)
                prog(s, $urandom_range(0, 63), $urandom_range(0, 3),
                     $urandom_range(0, 63), $urandom_range(0, 7));
            for (int f = 0; f < 6; f++) begin
                int ch;
                ch = $urandom_range(0, 3);
                if (ch == 3) drop_frame();
                else run_frame(ch, $urandom_range(0, 3), 1'($urandom),
                               1'($urandom), $urandom_range(0, 3));
            end
        end

        // Reset asserted in the middle of a MAC sequence.
        in_valid = 1'b1;
        in_ch    = CH_W'(0);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("pre_reset/in_mac", 32'(data_re & coef_re), 1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_cyc("async_reset", E_IDLE, 0, 0, 0, 0, 0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 30; j++) begin
            expect_cyc("post_reset", E_IDLE, -1, -1, -1, -1, -1);
            step();
        end
        // Cleared table: every stage runs len=0 at base 0 with rd 0.
        run_frame(2, 0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
